plot_arbiter: RTL

PLOT_ARBITER -- requirements
Module: plot_arbiter

---
 rtl/plot_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/plot_arbiter.sv
// Arbitrates three pixel sources (player one, player two, CPU plotter) onto a
// single VGA adapter write port. Round-robin grant with a bounded hold time
// and a one-cycle turnaround between owners; the pixel path is registered.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no owner; pick a round-robin winner when any req is high
// GRANT   | owner's pixels are forwarded; hold counter runs
// RELEASE | bus turnaround cycle; owner recorded as last for fairness
module plot_arbiter #(
    parameter logic [7:0] TIMEOUT = 8'd200
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [2:0] req,
    input  logic [2:0] wr,
    input  logic [7:0] x0,
    input  logic [7:0] x1,
    input  logic [7:0] x2,
    input  logic [6:0] y0,
    input  logic [6:0] y1,
    input  logic [6:0] y2,
    input  logic [2:0] c0,
    input  logic [2:0] c1,
    input  logic [2:0] c2,
    output logic [2:0] gnt,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       timeout
);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RELEASE} state_t;

    // A hold limit below one cycle makes no sense; clamp it to one.
    localparam logic [7:0] HOLD_MAX  = (TIMEOUT < 8'd2) ? 8'd1 : TIMEOUT;
    localparam logic [7:0] HOLD_LAST = HOLD_MAX - 8'd1;

    state_t     state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] last_q, last_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] gnt_q, gnt_d;
    logic       timeout_q, timeout_d;
    logic [7:0] vga_x_q, vga_x_d;
    logic [6:0] vga_y_q, vga_y_d;
    logic [2:0] vga_colour_q, vga_colour_d;
    logic       vga_plot_q, vga_plot_d;

    logic [1:0] cand1, cand2, winner;

    function automatic logic [1:0] next_idx(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    // Round-robin winner: search upward starting just after the last owner.
    always_comb begin
        cand1  = next_idx(last_q);
        cand2  = next_idx(cand1);
        winner = last_q;
        if (req[cand1]) begin
            winner = cand1;
        end else if (req[cand2]) begin
            winner = cand2;
        end
    end

    // Next-state, grant, hold counter and timeout pulse.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                gnt_d = 3'b000;
                if (req != 3'b000) begin
                    owner_d = winner;
                    gnt_d   = 3'b001 << winner;
                    cnt_d   = 8'd0;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (!req[owner_q]) begin
                    gnt_d   = 3'b000;
                    state_d = S_RELEASE;
                end else if (cnt_q == HOLD_LAST) begin
                    gnt_d     = 3'b000;
                    timeout_d = 1'b1;
                    state_d   = S_RELEASE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RELEASE: begin
                gnt_d   = 3'b000;
                last_d  = owner_q;
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = 3'b000;
                state_d = S_IDLE;
            end
        endcase
    end

    // Pixel path: forward the current owner's pixel; hold coordinates otherwise.
    always_comb begin
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        vga_plot_d   = 1'b0;
        if (gnt_q != 3'b000) begin
            case (owner_q)
                2'd0: begin
                    vga_x_d = x0; vga_y_d = y0; vga_colour_d = c0; vga_plot_d = wr[0];
                end
                2'd1: begin
                    vga_x_d = x1; vga_y_d = y1; vga_colour_d = c1; vga_plot_d = wr[1];
                end
                default: begin
                    vga_x_d = x2; vga_y_d = y2; vga_colour_d = c2; vga_plot_d = wr[2];
                end
            endcase
        end
    end

    // State and output registers; reset makes requester 0 first in line.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            owner_q      <= 2'd0;
            last_q       <= 2'd2;
            cnt_q        <= 8'd0;
            gnt_q        <= 3'b000;
            timeout_q    <= 1'b0;
            vga_x_q      <= 8'd0;
            vga_y_q      <= 7'd0;
            vga_colour_q <= 3'd0;
            vga_plot_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            gnt_q        <= gnt_d;
            timeout_q    <= timeout_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
        end
    end

    assign gnt        = gnt_q;
    assign timeout    = timeout_q;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign vga_plot   = vga_plot_q;

endmodule
